// File: rtl/cam_capture_ctrl_if.sv
// Frame-buffer write port bundle for cam_capture_ctrl.
// master: capture controller drives addr/data/strobe; slave: buffer samples them.
interface cam_capture_ctrl_if #(
    parameter int AW = 15
) ();
    logic [AW-1:0] mem_px_addr;
    logic [11:0]   mem_px_data;
    logic          px_wr;

    modport master (output mem_px_addr, mem_px_data, px_wr);
    modport slave  (input  mem_px_addr, mem_px_data, px_wr);
endinterface

// File: rtl/cam_capture_ctrl.sv
// OV7670 RGB444 capture sequencer: oversamples camera pins, packs byte pairs
// into 12-bit pixels and writes them linearly into the frame buffer.
// Ports: clk, rst (sync, active high), CAM_pclk/CAM_vsync/CAM_href/CAM_px_data
// camera pins, wr (buffer write bundle: mem_px_addr, mem_px_data, px_wr),
// frame_done (1-cycle pulse), line_err (sticky until next frame start).
// Option CAM_SNAPSHOT_EN: adds snap_req/snap_busy for single-frame capture.
module cam_capture_ctrl #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int AW    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CAM_pclk,
    input  logic        CAM_vsync,
    input  logic        CAM_href,
    input  logic [7:0]  CAM_px_data,
    cam_capture_ctrl_if.master wr,
    output logic        frame_done,
    output logic        line_err
`ifdef CAM_SNAPSHOT_EN
    ,
    input  logic        snap_req,
    output logic        snap_busy
`endif
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CW    = AW + 1;
    localparam int LW    = $clog2(IMG_W + 2);
    localparam int HW    = $clog2(IMG_H + 2);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        WAIT_HREF,
        BYTE1,
        BYTE2
    } state_t;

    // {pclk, vsync, href, data} travel together so data stays aligned
    logic [10:0] sync1, sync2, sync3;
    logic        rise_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            rise_r <= 1'b0;
        end else begin
            sync1  <= {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data};
            sync2  <= sync1;
            sync3  <= sync2;
            rise_r <= sync2[10] & ~sync3[10];
        end
    end

    logic       vsync_r, href_r;
    logic [7:0] data_r;

    assign vsync_r = sync3[9];
    assign href_r  = sync3[8];
    assign data_r  = sync3[7:0];

    state_t        state;
    logic [3:0]    byte1_lo;
    logic [CW-1:0] px_cnt;
    logic [LW-1:0] line_px;
    logic [HW-1:0] line_cnt;
    logic          done_ok;

    // Line count check also rejects a frame cut off with href still high
    assign done_ok = (state == WAIT_HREF) && !line_err &&
                     (px_cnt == CW'(TOTAL)) && (line_cnt == HW'(IMG_H));

`ifdef CAM_SNAPSHOT_EN
    localparam state_t END_STATE = IDLE;
`else
    localparam state_t END_STATE = WAIT_FRAME;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            byte1_lo       <= '0;
            px_cnt         <= '0;
            line_px        <= '0;
            line_cnt       <= '0;
            wr.mem_px_addr <= '0;
            wr.mem_px_data <= '0;
            wr.px_wr       <= 1'b0;
            frame_done     <= 1'b0;
            line_err       <= 1'b0;
`ifdef CAM_SNAPSHOT_EN
            snap_busy      <= 1'b0;
`endif
        end else begin
            wr.px_wr   <= 1'b0;
            frame_done <= 1'b0;
`ifdef CAM_SNAPSHOT_EN
            if (state == IDLE && snap_req && !snap_busy)
                snap_busy <= 1'b1;
`endif
            if (rise_r) begin
                unique case (state)
                    IDLE: begin
`ifdef CAM_SNAPSHOT_EN
                        if (vsync_r && snap_busy)
                            state <= WAIT_FRAME;
`else
                        if (vsync_r)
                            state <= WAIT_FRAME;
`endif
                    end
                    WAIT_FRAME: begin
                        if (!vsync_r) begin
                            state          <= WAIT_HREF;
                            px_cnt         <= '0;
                            wr.mem_px_addr <= '0;
                            line_px        <= '0;
                            line_cnt       <= '0;
                            line_err       <= 1'b0;
                        end
                    end
                    WAIT_HREF, BYTE1, BYTE2: begin
                        if (vsync_r) begin
                            // vsync wins over href; any pending byte is dropped
                            frame_done <= done_ok;
                            state      <= END_STATE;
`ifdef CAM_SNAPSHOT_EN
                            snap_busy  <= 1'b0;
`endif
                        end else if (!href_r) begin
                            if (state != WAIT_HREF) begin
                                if (state == BYTE2 ||
                                    line_px != LW'(IMG_W))
                                    line_err <= 1'b1;
                                if (line_cnt != '1)
                                    line_cnt <= line_cnt + HW'(1);
                                line_px <= '0;
                            end
                            state <= WAIT_HREF;
                        end else if (state == BYTE2) begin
                            if (line_px != '1)
                                line_px <= line_px + LW'(1);
                            if (px_cnt == CW'(TOTAL)) begin
                                // buffer full: drop pixel, never wrap
                                line_err <= 1'b1;
                            end else begin
                                wr.px_wr       <= 1'b1;
                                wr.mem_px_addr <= px_cnt[AW-1:0];
                                wr.mem_px_data <= {byte1_lo, data_r};
                                px_cnt         <= px_cnt + CW'(1);
                            end
                            state <= BYTE1;
                        end else begin
                            byte1_lo <= data_r[3:0];
                            state    <= BYTE2;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
